// File: rtl/adder_pkg.sv
// adder_pkg: shared types, parameter checks and helpers for the multi-cycle adder
package adder_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int MIN_WIDTH = 1;
  localparam int MIN_DIGIT = 1;
  function automatic bit params_ok(input int width, input int digit);
    return width >= MIN_WIDTH && digit >= MIN_DIGIT && digit <= width && width % digit == 0;
  endfunction
  function automatic int steps(input int width, input int digit);
    return digit > 0 ? width / digit : 1;
  endfunction
endpackage

// File: rtl/adder_slice.sv
// adder_slice: combinational DIGIT-bit ripple of full-adder cells
module adder_slice #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_top
);
  always_comb begin
    logic c;
    c = ci;
    c_top = ci;
    s = '0;
    for (int i = 0; i < DIGIT; i++) begin
      c_top = i == DIGIT - 1 ? c : c_top;
      s[i] = x[i] ^ y[i] ^ c;
      c = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    co = c;
  end
endmodule

// File: rtl/multicycle_adder.sv
// multicycle_adder: add/subtract WIDTH-bit operands DIGIT bits per cycle, LSB digit first,
// through one shared ripple slice, with valid/ready handshakes on both sides.
module multicycle_adder import adder_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int STEPS = steps(WIDTH, DIGIT);
  localparam int CW = $clog2(STEPS + 1);

  if (!params_ok(WIDTH, DIGIT)) begin : g_bad_params
    $error("multicycle_adder: illegal WIDTH/DIGIT combination");
  end

  state_t state, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nxt;
  logic [WIDTH+DIGIT-1:0] sum_cat;
  logic [CW-1:0] step_q;
  logic c_q, last;
  logic [DIGIT-1:0] sl_s;
  logic sl_co, sl_ctop;

  adder_slice #(.DIGIT(DIGIT)) u_slice (
    .x    (a_sh[DIGIT-1:0]),
    .y    (b_sh[DIGIT-1:0]),
    .ci   (c_q),
    .s    (sl_s),
    .co   (sl_co),
    .c_top(sl_ctop)
  );

  assign last = step_q == CW'(STEPS - 1);
  // new digit enters at the top while the partial sum slides toward the LSB
  assign sum_cat = {sl_s, sum_sh};
  assign sum_nxt = WIDTH'(sum_cat >> DIGIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    state_d = in_valid ? BUSY : IDLE;
      BUSY:    state_d = last ? DONE : BUSY;
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
  end

  // subtraction is a + ~b + ~borrow; the visible result only updates on the last step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      sum_sh <= '0;
      c_q <= 1'b0;
      step_q <= '0;
      sum <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_sh <= a;
      b_sh <= sub ? ~b : b;
      c_q <= sub ^ cin;
      step_q <= '0;
    end else if (state == BUSY) begin
      a_sh <= a_sh >> DIGIT;
      b_sh <= b_sh >> DIGIT;
      sum_sh <= sum_nxt;
      c_q <= sl_co;
      step_q <= last ? step_q : step_q + CW'(1);
      if (last) begin
        sum <= sum_nxt;
        cout <= sl_co;
        ovf <= sl_ctop ^ sl_co;
      end
    end
  end
endmodule

// File: tb/tb_multicycle_adder.sv
// tb_multicycle_adder: directed and randomized checks of multicycle_adder against an arithmetic model
module tb_multicycle_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0, sub = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic in_ready, out_valid, cout, ovf;
  logic [7:0] sum;
  int total = 0;
  int bad = 0;

  logic [15:0] ra = '0, rb = '0;
  logic rcin = 1'b0, rsub = 1'b0, sw_or = 1'b0;
  logic sw_iv[4] = '{1'b0, 1'b0, 1'b0, 1'b0};
  logic sw_ir[4], sw_ov[4], sw_co[4], sw_of[4];
  logic [7:0] s1, s2;
  logic [15:0] s3;
  logic [4:0] s4;
  logic [15:0] sw_sum[4];

  always #5 clk = ~clk;

  multicycle_adder #(.WIDTH(8), .DIGIT(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf));
  multicycle_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_iv[0]), .in_ready(sw_ir[0]), .a(ra[7:0]), .b(rb[7:0]),
    .cin(rcin), .sub(rsub), .out_valid(sw_ov[0]), .out_ready(sw_or), .sum(s1),
    .cout(sw_co[0]), .ovf(sw_of[0]));
  multicycle_adder #(.WIDTH(8), .DIGIT(8)) u_w8d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_iv[1]), .in_ready(sw_ir[1]), .a(ra[7:0]), .b(rb[7:0]),
    .cin(rcin), .sub(rsub), .out_valid(sw_ov[1]), .out_ready(sw_or), .sum(s2),
    .cout(sw_co[1]), .ovf(sw_of[1]));
  multicycle_adder #(.WIDTH(16), .DIGIT(4)) u_w16d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_iv[2]), .in_ready(sw_ir[2]), .a(ra), .b(rb),
    .cin(rcin), .sub(rsub), .out_valid(sw_ov[2]), .out_ready(sw_or), .sum(s3),
    .cout(sw_co[2]), .ovf(sw_of[2]));
  multicycle_adder #(.WIDTH(5), .DIGIT(5)) u_w5d5 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_iv[3]), .in_ready(sw_ir[3]), .a(ra[4:0]), .b(rb[4:0]),
    .cin(rcin), .sub(rsub), .out_valid(sw_ov[3]), .out_ready(sw_or), .sum(s4),
    .cout(sw_co[3]), .ovf(sw_of[3]));

  assign sw_sum[0] = {8'd0, s1};
  assign sw_sum[1] = {8'd0, s2};
  assign sw_sum[2] = s3;
  assign sw_sum[3] = {11'd0, s4};

  // integer arithmetic reference: exact result, then wrap, borrow and signed range test
  function automatic void model(input int w, input logic [15:0] xa, xb, input logic xc, xs,
                                output logic [15:0] rs, output logic rc, ro);
    longint m = (longint'(1) << w);
    longint ua = longint'(xa) & (m - 1);
    longint ub = longint'(xb) & (m - 1);
    longint sa = ua >= m / 2 ? ua - m : ua;
    longint sb = ub >= m / 2 ? ub - m : ub;
    longint full = xs ? ua - ub - longint'(xc) : ua + ub + longint'(xc);
    longint sr = xs ? sa - sb - longint'(xc) : sa + sb + longint'(xc);
    rs = 16'(full & (m - 1));
    rc = xs ? (ua >= ub + longint'(xc)) : (full >= m);
    ro = sr < -(m / 2) || sr >= m / 2;
  endfunction

  task automatic run_op(input logic [7:0] xa, xb, input logic xc, xs,
                        output logic [7:0] rs, output logic rc, ro, output int lat);
    a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    rs = sum; rc = cout; ro = ovf;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total += 5;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    if (sum !== 8'h00) begin bad++; $display("FAIL reset_sum got=%h want=00", sum); end
    if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b want=0", cout); end
    if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    logic [7:0] ta[5] = '{8'h3C, 8'h7F, 8'hFF, 8'h05, 8'h80};
    logic [7:0] tb[5] = '{8'h0F, 8'h01, 8'h00, 8'h07, 8'h01};
    logic tc[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic ts[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] te[5] = '{8'h4B, 8'h80, 8'h00, 8'hFE, 8'h7F};
    logic tco[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic tov[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] rs;
    logic rc, ro;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], tc[i], ts[i], rs, rc, ro, lat);
      total += 4;
      if (rs !== te[i]) begin bad++; $display("FAIL vec%0d_sum got=%h want=%h", i, rs, te[i]); end
      if (rc !== tco[i]) begin bad++; $display("FAIL vec%0d_cout got=%b want=%b", i, rc, tco[i]); end
      if (ro !== tov[i]) begin bad++; $display("FAIL vec%0d_ovf got=%b want=%b", i, ro, tov[i]); end
      if (lat != 4) begin bad++; $display("FAIL vec%0d_latency got=%0d want=4", i, lat); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] es;
    logic ec, eo;
    int lat = 0;
    model(8, 16'h00A7, 16'h0063, 1'b1, 1'b0, es, ec, eo);
    a = 8'hA7; b = 8'h63; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    for (int i = 0; i < 5; i++) begin
      total += 4;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid cyc%0d got=%b want=1", i, out_valid); end
      if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc%0d got=%b want=0", i, in_ready); end
      if (sum !== es[7:0]) begin bad++; $display("FAIL bp_sum cyc%0d got=%h want=%h", i, sum, es[7:0]); end
      if (cout !== ec || ovf !== eo) begin
        bad++; $display("FAIL bp_flags cyc%0d got=%b%b want=%b%b", i, cout, ovf, ec, eo);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if (sum !== es[7:0]) begin bad++; $display("FAIL bp_sum_after_handshake got=%h want=%h", sum, es[7:0]); end
  endtask

  task automatic test_busy_noise();
    for (int n = 0; n < 8; n++) begin
      logic [15:0] xa = 16'($urandom_range(0, 255)), xb = 16'($urandom_range(0, 255)), es;
      logic xc = 1'($urandom_range(0, 1)), xs = 1'($urandom_range(0, 1)), ec, eo;
      int lat = 0;
      model(8, xa, xb, xc, xs, es, ec, eo);
      a = xa[7:0]; b = xb[7:0]; cin = xc; sub = xs; in_valid = 1'b1;
      @(posedge clk); #1;
      while (!out_valid && lat < 50) begin
        in_valid = 1'($urandom_range(0, 1));
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        @(posedge clk); #1;
        lat++;
      end
      in_valid = 1'b0;
      total += 3;
      if (sum !== es[7:0]) begin bad++; $display("FAIL noise%0d_sum got=%h want=%h", n, sum, es[7:0]); end
      if (cout !== ec || ovf !== eo) begin
        bad++; $display("FAIL noise%0d_flags got=%b%b want=%b%b", n, cout, ovf, ec, eo);
      end
      if (lat != 4) begin bad++; $display("FAIL noise%0d_latency got=%0d want=4", n, lat); end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rs;
    logic rc, ro;
    int lat;
    a = 8'h55; b = 8'h22; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total += 3;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
    if (sum !== 8'h00) begin bad++; $display("FAIL midrst_sum got=%h want=00", sum); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(8'h12, 8'h34, 1'b0, 1'b0, rs, rc, ro, lat);
    total += 2;
    if (rs !== 8'h46) begin bad++; $display("FAIL midrst_after_sum got=%h want=46", rs); end
    if (lat != 4) begin bad++; $display("FAIL midrst_after_latency got=%0d want=4", lat); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] qs[$];
    logic qc[$], qo[$];
    int last_acc = -1, accepts = 0, done = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (out_valid) begin
        total += 2;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_overlap cyc%0d in_ready=%b want=0", cyc, in_ready); end
        if (qs.size() == 0) begin
          bad++; $display("FAIL b2b_unexpected_result cyc%0d got=%h want=none", cyc, sum);
        end else begin
          logic [7:0] es = qs.pop_front();
          logic ec = qc.pop_front(), eo = qo.pop_front();
          if (sum !== es || cout !== ec || ovf !== eo) begin
            bad++; $display("FAIL b2b_result cyc%0d got=%h/%b/%b want=%h/%b/%b", cyc, sum, cout, ovf, es, ec, eo);
          end
          done++;
        end
      end
      if (in_ready) begin
        logic [15:0] es;
        logic ec, eo;
        if (last_acc >= 0) begin
          total++;
          if (cyc - last_acc != 6) begin bad++; $display("FAIL b2b_interval got=%0d want=6", cyc - last_acc); end
        end
        last_acc = cyc;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        model(8, {8'd0, a}, {8'd0, b}, cin, sub, es, ec, eo);
        qs.push_back(es[7:0]); qc.push_back(ec); qo.push_back(eo);
        accepts++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !in_ready; i++) begin @(posedge clk); #1; end
    out_ready = 1'b0;
    total += 2;
    if (done < 5) begin bad++; $display("FAIL b2b_throughput got=%0d want>=5", done); end
    if (!in_ready) begin bad++; $display("FAIL b2b_drain in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_sweep(input int k, input int w, input int st);
    for (int n = 0; n < 1000; n++) begin
      logic [15:0] es;
      logic ec, eo;
      int lat = 0;
      ra = 16'($urandom); rb = 16'($urandom); rcin = 1'($urandom); rsub = 1'($urandom);
      model(w, ra, rb, rcin, rsub, es, ec, eo);
      sw_iv[k] = 1'b1;
      @(posedge clk); #1;
      sw_iv[k] = 1'b0;
      while (!sw_ov[k] && lat < 50) begin @(posedge clk); #1; lat++; end
      total += 4;
      if (sw_sum[k] !== es) begin bad++; $display("FAIL sweep%0d_%0d_sum got=%h want=%h", k, n, sw_sum[k], es); end
      if (sw_co[k] !== ec) begin bad++; $display("FAIL sweep%0d_%0d_cout got=%b want=%b", k, n, sw_co[k], ec); end
      if (sw_of[k] !== eo) begin bad++; $display("FAIL sweep%0d_%0d_ovf got=%b want=%b", k, n, sw_of[k], eo); end
      if (lat != st) begin bad++; $display("FAIL sweep%0d_%0d_latency got=%0d want=%0d", k, n, lat, st); end
      sw_or = 1'b1;
      @(posedge clk); #1;
      sw_or = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_busy_noise();
    test_reset_mid();
    test_back_to_back();
    test_sweep(0, 8, 8);
    test_sweep(1, 8, 1);
    test_sweep(2, 16, 4);
    test_sweep(3, 5, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_adder.md
# multicycle_adder

Parametrised multi-cycle adder/subtractor. Two WIDTH-bit operands are added or subtracted DIGIT bits per clock, least-significant digit first, through one shared DIGIT-bit ripple slice. It returns sum, carry-out and signed overflow over a valid/ready handshake. It is the sequential, width- and mode-generalised successor to the gate-level full adder in the arithmetic datapath, trading latency for area.

## Interface

Parameters:
- WIDTH, 8, operand/result width in bits; must be ≥ 1.
- DIGIT, 2, bits processed per cycle; must satisfy 1 ≤ DIGIT ≤ WIDTH and WIDTH % DIGIT == 0; elaboration error otherwise.
- Derived: STEPS = WIDTH/DIGIT.

Ports:
- Clock and reset (already decided): one clock, `clk`; reset `rst_n`, asynchronous, active-low.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a  in  WIDTH  operand A (unsigned or two's complement).
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0: a+b+cin; 1: a−b−cin.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  final carry out of MSB.
  - For sub, 1 means no borrow.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation

- States: IDLE, BUSY, DONE.
- **IDLE:**
  - in_ready=1.
  - On in_valid&&in_ready: latch a into A_sh and (sub ? ~b : b) into B_sh.
  - Carry register c ← (sub ? ~cin : cin).
  - Step counter ← 0; go to BUSY.
- **BUSY:** each cycle:
  - The slice adds A_sh[DIGIT-1:0] + B_sh[DIGIT-1:0] + c.
  - Slice result enters the top DIGIT bits of the sum shift register, which shifts right by DIGIT.
  - A_sh and B_sh shift right by DIGIT; c ← slice carry.
  - On step STEPS-1: latch cout ← slice carry and ovf ← slice carry-into-top-bit XOR slice carry; go to DONE.
  - Otherwise increment the step counter.
- **DONE:**
  - out_valid=1; sum, cout and ovf held stable.
  - On out_ready go to IDLE.
- After a handshake, sum/cout/ovf keep their last values until the next result is loaded. They do not change while out_valid=1.
- Input ports are ignored outside the IDLE accept cycle. Operand changes during BUSY must not affect the result.
- in_valid while BUSY/DONE: no capture, no error.
- Reset (asynchronous, any state, including mid-BUSY):
  - State → IDLE; operation aborted, no partial result.
  - Reset values: in_ready=1, out_valid=0, sum=0, cout=0, ovf=0; counter, shift registers and c cleared.
- DIGIT=WIDTH: STEPS=1, single BUSY cycle. DIGIT=1: bit-serial.

## Timing

- Accept at rising edge t; out_valid rises at edge t+STEPS. Latency is STEPS cycles.
- out_ready sampled in DONE. With out_ready held high, return to IDLE at edge t+STEPS+1; the next accept is possible at t+STEPS+2.
- Minimum initiation interval: STEPS+2 cycles. No overlap of operations.
- in_ready and out_valid are decoded from registered state only, with no combinational input-to-output path.
- Back-to-back: a new accept is only possible in IDLE, never in the same cycle as the output handshake.

## Structure

- Package `adder_pkg`:
  - State enum typedef (IDLE, BUSY, DONE).
  - Function `steps(width, digit)`.
  - Parameter-legality check constants.
- Sub-module `adder_slice`: combinational, parameter DIGIT.
  - Inputs: x[DIGIT], y[DIGIT], ci.
  - Outputs: s[DIGIT], co, c_top (carry into bit DIGIT-1).
  - Ripple of full-adder cells.
- Top: FSM, step counter ($clog2(STEPS+1) bits), A/B/sum shift registers, carry register, output flags.

## Test plan

- WIDTH=8, DIGIT=2, add 8'h3C+8'h0F, cin=0 → sum=8'h4B, cout=0, ovf=0; out_valid exactly 4 cycles after accept.
- Add 8'h7F+8'h01 → 8'h80, cout=0, ovf=1. Add 8'hFF+8'h00, cin=1 → 8'h00, cout=1, ovf=0.
- Sub 8'h05−8'h07, cin=0 → 8'hFE, cout=0, ovf=0. Sub 8'h80−8'h01 → 8'h7F, cout=1, ovf=1.
- Backpressure:
  - out_ready low 5 cycles → out_valid and sum held constant, in_ready=0 throughout.
  - in_valid pulses and changes on a/b during BUSY → no effect on the result.
- Drop rst_n at step 2 of 4 → immediately in_ready=1, out_valid=0, sum=0. After release, 8'h12+8'h34 → 8'h46.
- Parameter sweep (WIDTH, DIGIT) ∈ {(8,1), (8,8), (16,4), (5,5)}: 1000 random ops each vs behavioural model of sum/cout/ovf; latency = WIDTH/DIGIT.
